// File: rtl/grom_led_driver_if.sv
// Display-byte and LED pin bundle between the grom CPU side and the LED driver.
interface grom_led_driver_if;
  logic [7:0] display_in;
  logic       display_we;
  logic       hlt;
  logic       led_r;
  logic       led_g;
  logic       led_b;

  modport master (
    output display_in, display_we, hlt,
    input  led_r, led_g, led_b
  );

  modport slave (
    input  display_in, display_we, hlt,
    output led_r, led_g, led_b
  );
endinterface

// File: rtl/grom_led_driver.sv
// grom_led_driver: active-low RGB PWM stage for the CPU display byte; GROM_LED_GAMMA_EN selects gamma thresholds.
// Latency: a written byte applies at the next PWM period boundary; LED pins are registered one cycle behind.
// Backpressure: none; every write is accepted and the last write before a boundary wins.
module grom_led_driver #(
  parameter int PRESCALE      = 1,
  parameter int BLINK_PERIODS = 16
) (
  input logic              clk,
  input logic              reset,
  grom_led_driver_if.slave disp
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_PERIODS - 1);

  logic [PW-1:0] ps_cnt;
  logic [4:0]    pwm_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blank;
  logic [7:0]    shadow;
  logic [7:0]    active;
  logic [2:0]    led_q;
  logic          tick;
  logic          boundary;
  logic [4:0]    level;
  logic [5:0]    th;
  logic [2:0]    on_vec;

  assign tick     = (ps_cnt == PS_LAST);
  assign boundary = tick && (pwm_cnt == 5'd31);
  assign level    = active[7:3];

`ifdef GROM_LED_GAMMA_EN
  logic [10:0] lvl_p1;
  always_comb begin
    lvl_p1 = 11'(level) + 11'd1;
    th     = 6'((lvl_p1 * lvl_p1) >> 5);
  end
`else
  assign th = {1'b0, level} + 6'd1;
`endif

  assign on_vec = active[2:0] & {3{({1'b0, pwm_cnt} < th) & ~blank}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_cnt    <= '0;
      pwm_cnt   <= '0;
      blink_cnt <= '0;
      blank     <= 1'b0;
      shadow    <= '0;
      active    <= '0;
      led_q     <= 3'b111;
    end else begin
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
      if (tick)
        pwm_cnt <= pwm_cnt + 5'd1;
      if (disp.display_we)
        shadow <= disp.display_in;
      // active takes the pre-edge shadow, so a write on the boundary waits one period
      if (boundary)
        active <= shadow;
      if (!disp.hlt) begin
        blink_cnt <= '0;
        blank     <= 1'b0;
      end else if (boundary) begin
        if (blink_cnt == BL_LAST) begin
          blink_cnt <= '0;
          blank     <= ~blank;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      led_q <= ~on_vec;
    end
  end

  assign disp.led_r = led_q[0];
  assign disp.led_g = led_q[1];
  assign disp.led_b = led_q[2];
endmodule

// File: tb/tb_grom_led_driver.sv
// Directed bench for grom_led_driver with PRESCALE=1, BLINK_PERIODS=2; PWM masks are hand-computed.
module tb_grom_led_driver;
  logic clk;
  logic rst;
  int   edge_n;
  int   total = 0;
  int   bad   = 0;

  grom_led_driver_if ifc ();

  grom_led_driver #(.PRESCALE(1), .BLINK_PERIODS(2)) dut (
    .clk   (clk),
    .reset (rst),
    .disp  (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges since reset release; with PRESCALE=1 the PWM counter equals edge_n mod 32.
  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sync_boundary(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((edge_n % 32) != 0 && n < 100);
    chk({tag, " sync"}, 32'(edge_n % 32), 32'd0);
  endtask

  // The write strobe lands on the edge where edge_n becomes tgt (mod 32).
  task automatic write_at(input string tag, input logic [7:0] b, input int tgt);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((edge_n % 32) != ((tgt + 31) % 32) && n < 100);
    ifc.display_in = b;
    ifc.display_we = 1'b1;
    @(posedge clk); #1;
    ifc.display_we = 1'b0;
    chk({tag, " phase"}, 32'(edge_n % 32), 32'(tgt));
  endtask

  // One full PWM period; bit j set means the LED was lit at counter value j.
  task automatic period(input string tag, input logic [31:0] er, input logic [31:0] eg,
                        input logic [31:0] eb);
    logic [31:0] r, g, b;
    for (int j = 0; j < 32; j++) begin
      @(posedge clk);
      @(negedge clk);
      r[j] = ~ifc.led_r;
      g[j] = ~ifc.led_g;
      b[j] = ~ifc.led_b;
    end
    chk({tag, " r"}, r, er);
    chk({tag, " g"}, g, eg);
    chk({tag, " b"}, b, eb);
  endtask

  function automatic logic [31:0] leds3();
    return 32'({ifc.led_b, ifc.led_g, ifc.led_r});
  endfunction

  initial begin
    int z;
    rst            = 1'b1;
    ifc.display_in = 8'h00;
    ifc.display_we = 1'b0;
    ifc.hlt        = 1'b0;
    #12;
    chk("reset leds", leds3(), 32'h7);
    @(negedge clk);
    rst = 1'b0;

    z = 0;
    repeat (200) begin
      @(posedge clk);
      @(negedge clk);
      if (ifc.led_r !== 1'b1 || ifc.led_g !== 1'b1 || ifc.led_b !== 1'b1) z++;
    end
    chk("idle lit samples", 32'(z), 32'd0);

    write_at("ff", 8'hFF, 10);
    sync_boundary("ff");
    period("ff p1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    period("ff p2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Mid-period async reset while all channels are lit
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async reset leds", leds3(), 32'h7);
    chk("async reset active", 32'(dut.active), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sync_boundary("post reset");
    period("post reset", 32'h0, 32'h0, 32'h0);

    write_at("lvl0", 8'h01, 7);
    sync_boundary("lvl0");
    period("lvl0 red", 32'h0000_0001, 32'h0, 32'h0);

    write_at("lvl15", 8'h7A, 3);
    sync_boundary("lvl15");
    period("lvl15 grn", 32'h0, 32'h0000_FFFF, 32'h0);

    write_at("pre bnd", 8'h7C, 30);
    sync_boundary("pre bnd");
    period("switch blue", 32'h0, 32'h0, 32'h0000_FFFF);

    write_at("on bnd", 8'h7A, 0);
    period("on bnd old", 32'h0, 32'h0, 32'h0000_FFFF);
    period("on bnd new", 32'h0, 32'h0000_FFFF, 32'h0);

`ifdef GROM_LED_GAMMA_EN
    write_at("gam15", 8'h7A, 12);
    sync_boundary("gam15");
    period("gamma lvl15", 32'h0, 32'h0000_00FF, 32'h0);
    write_at("gam0", 8'h02, 12);
    sync_boundary("gam0");
    period("gamma lvl0", 32'h0, 32'h0, 32'h0);
`else
    write_at("lin0", 8'h02, 12);
    sync_boundary("lin0");
    period("linear lvl0 grn", 32'h0, 32'h0000_0001, 32'h0);
`endif

    write_at("blink", 8'hFF, 5);
    sync_boundary("blink load");
    sync_boundary("blink start");
    ifc.hlt = 1'b1;
    period("blink on1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    period("blink on2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    period("blink off1", 32'h0, 32'h0, 32'h0);
    period("blink off2", 32'h0, 32'h0, 32'h0);
    period("blink on3", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    period("blink on4", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    period("blink off3", 32'h0, 32'h0, 32'h0);
    ifc.hlt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("unblank leds", leds3(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
